// File: rtl/sao_stat_accum_if.sv
// rtl/sao_stat_accum_if.sv - pixel input and bin output bundle for sao_stat_accum
interface sao_stat_accum_if #(
  parameter int num_pix_CTU_log2 = 5,
  parameter int diff_clip_bit    = 4,
  parameter int num_CTU          = 2 * num_pix_CTU_log2 - 1,
  parameter int sum_CTU_len      = num_CTU + diff_clip_bit,
  parameter int state_len        = 6
);
  logic                    pix_valid;
  logic signed [8:0]       diff;
  logic [3:0][2:0]         eo_cat;
  logic [4:0]              bo_band;
  logic                    ctu_end;
  logic                    out_ready;
  logic                    out_valid;
  logic [state_len-1:0]    out_idx;
  logic [num_CTU:0]        num_blk_CTU;
  logic signed [sum_CTU_len:0] sum_blk_CTU;

  modport master (
    output pix_valid, diff, eo_cat, bo_band, ctu_end, out_ready,
    input  out_valid, out_idx, num_blk_CTU, sum_blk_CTU
  );

  modport slave (
    input  pix_valid, diff, eo_cat, bo_band, ctu_end, out_ready,
    output out_valid, out_idx, num_blk_CTU, sum_blk_CTU
  );
endinterface

// File: rtl/sao_stat_accum.sv
// rtl/sao_stat_accum.sv - per-CTU SAO edge/band offset statistics, drained bin by bin
module sao_stat_accum #(
  parameter int num_pix_CTU_log2 = 5,
  parameter int diff_clip_bit    = 4,
  parameter int num_CTU          = 2 * num_pix_CTU_log2 - 1,
  parameter int sum_CTU_len      = num_CTU + diff_clip_bit,
  parameter int state_len        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  sao_stat_accum_if.slave  bus,
  output logic             busy,
  output logic             done
);
  localparam int num_bins = 48;
  localparam int cw = num_CTU + 1;
  localparam int sw = sum_CTU_len + 1;
  localparam int dw = diff_clip_bit + 1;
  localparam logic signed [8:0] clip_hi = 9'((1 << diff_clip_bit) - 1);
  localparam logic signed [8:0] clip_lo = 9'(-(1 << diff_clip_bit));
  localparam logic [state_len-1:0] last_idx = state_len'(num_bins - 1);
  localparam logic [cw-1:0] cnt_max = '1;
  localparam logic signed [sw-1:0] sum_max = {1'b0, {(sw-1){1'b1}}};
  localparam logic signed [sw-1:0] sum_min = {1'b1, {(sw-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [state_len-1:0]  idx;
  logic                  p_valid;
  logic signed [dw-1:0]  p_diff;
  logic [3:0][2:0]       p_cat;
  logic [4:0]            p_band;
  logic signed [dw-1:0]  diff_clip;
  logic signed [sw:0]    diff_ext;
  logic [num_bins-1:0]   bin_hit;
  logic [cw-1:0]         cnt_q   [num_bins];
  logic signed [sw-1:0]  sum_q   [num_bins];
  logic [cw-1:0]         cnt_nxt [num_bins];
  logic signed [sw-1:0]  sum_nxt [num_bins];
  logic signed [sw:0]    sum_ext [num_bins];
  logic                  accept, clear_bins, last_beat;

  assign accept     = (state == ACCUM) && bus.pix_valid;
  assign clear_bins = (state == IDLE) && start;
  assign last_beat  = (state == DRAIN) && bus.out_ready && (idx == last_idx);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = ACCUM;
      ACCUM:   if (bus.ctu_end) state_nxt = FLUSH;
      FLUSH:                    state_nxt = DRAIN;
      DRAIN:   if (last_beat)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy            = (state == ACCUM) || (state == DRAIN);
    bus.out_valid   = 1'b0;
    bus.out_idx     = '0;
    bus.num_blk_CTU = '0;
    bus.sum_blk_CTU = '0;
    if (state == DRAIN) begin
      bus.out_valid   = 1'b1;
      bus.out_idx     = idx;
      bus.num_blk_CTU = cnt_q[idx];
      bus.sum_blk_CTU = sum_q[idx];
    end
  end

  always_comb begin
    diff_clip = bus.diff[dw-1:0];
    if (bus.diff > clip_hi)      diff_clip = {1'b0, {diff_clip_bit{1'b1}}};
    else if (bus.diff < clip_lo) diff_clip = {1'b1, {diff_clip_bit{1'b0}}};
  end

  // One register stage between the pixel ports and the bin adders; FLUSH drains it.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_diff  <= '0;
      p_cat   <= '0;
      p_band  <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_diff <= diff_clip;
        p_cat  <= bus.eo_cat;
        p_band <= bus.bo_band;
      end
    end
  end

  assign diff_ext = {{(sw + 1 - dw){p_diff[dw-1]}}, p_diff};

  // Each EO class and the band index select distinct bins, so one pixel hits up to five.
  always_comb begin
    bin_hit = '0;
    for (int i = 0; i < 16; i++)
      bin_hit[i] = p_valid && (p_cat[i/4] == 3'(i % 4 + 1));
    for (int i = 16; i < num_bins; i++)
      bin_hit[i] = p_valid && (p_band == 5'(i - 16));
  end

  always_comb begin
    for (int i = 0; i < num_bins; i++) begin
      sum_ext[i] = {sum_q[i][sw-1], sum_q[i]} + diff_ext;
      if (sum_ext[i][sw] != sum_ext[i][sw-1])
        sum_nxt[i] = sum_ext[i][sw] ? sum_min : sum_max;
      else
        sum_nxt[i] = sum_ext[i][sw-1:0];
      cnt_nxt[i] = (cnt_q[i] == cnt_max) ? cnt_q[i] : cnt_q[i] + cw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_bins) begin
      for (int i = 0; i < num_bins; i++) begin
        cnt_q[i] <= '0;
        sum_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < num_bins; i++) begin
        if (bin_hit[i]) begin
          cnt_q[i] <= cnt_nxt[i];
          sum_q[i] <= sum_nxt[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      done <= 1'b0;
    end else begin
      done <= last_beat;
      if (state != DRAIN)     idx <= '0;
      else if (bus.out_ready) idx <= idx + state_len'(1);
    end
  end
endmodule

// File: tb/tb_sao_stat_accum.sv
// tb/tb_sao_stat_accum.sv - table-driven scoreboard bench for sao_stat_accum
module tb_sao_stat_accum;
  localparam int nb = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  sao_stat_accum_if #(.num_pix_CTU_log2(5), .diff_clip_bit(4)) bus ();

  sao_stat_accum #(.num_pix_CTU_log2(5), .diff_clip_bit(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              diff;
    logic [3:0][2:0] cat;
    int              band;
    int              contrib;
  } pix_t;

  typedef struct {
    int idx;
    int num;
    int sum;
  } beat_t;

  pix_t  tbl [13];
  beat_t sb [$];
  int    exp_cnt [nb];
  int    exp_sum [nb];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic pix_t mk(int d, int c0, int c1, int c2, int c3, int b, int ctb);
    pix_t p;
    p.diff = d;
    p.cat[0] = 3'(c0);
    p.cat[1] = 3'(c1);
    p.cat[2] = 3'(c2);
    p.cat[3] = 3'(c3);
    p.band = b;
    p.contrib = ctb;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pix_valid = 1'b0;
    bus.diff      = '0;
    bus.eo_cat    = '0;
    bus.bo_band   = '0;
    bus.ctu_end   = 1'b0;
    bus.out_ready = 1'b0;
    start         = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < nb; i++) begin
      exp_cnt[i] = 0;
      exp_sum[i] = 0;
    end
  endtask

  task automatic model_bump(input int b, input int c);
    int s;
    exp_cnt[b] = (exp_cnt[b] < 1023) ? exp_cnt[b] + 1 : 1023;
    s = exp_sum[b] + c;
    if (s > 8191)  s = 8191;
    if (s < -8192) s = -8192;
    exp_sum[b] = s;
  endtask

  task automatic model_pix(input pix_t p);
    for (int c = 0; c < 4; c++)
      if (p.cat[c] != 0) model_bump(c * 4 + int'(p.cat[c]) - 1, p.contrib);
    model_bump(16 + p.band, p.contrib);
  endtask

  task automatic run_ctu(input int lo, input int hi, input int reps, input bit end_on_pix);
    bit ended = 1'b0;
    model_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_accum", int'(busy), 1);
    for (int i = lo; i <= hi; i++) begin
      for (int r = 0; r < reps; r++) begin
        bus.pix_valid = 1'b1;
        bus.diff      = 9'(tbl[i].diff);
        bus.eo_cat    = tbl[i].cat;
        bus.bo_band   = 5'(tbl[i].band);
        bus.ctu_end   = end_on_pix && (i == hi) && (r == reps - 1);
        if (bus.ctu_end) ended = 1'b1;
        model_pix(tbl[i]);
        tick();
      end
    end
    bus.pix_valid = 1'b0;
    if (!ended) begin
      bus.ctu_end = 1'b1;
      tick();
    end
    bus.ctu_end = 1'b0;
    chk("flush_valid", int'(bus.out_valid), 0);
    tick();
  endtask

  task automatic do_drain(input bit stall, input bit noise, input int rst_at);
    int    cyc = 0;
    int    stall_idx [5] = '{0, 1, 1, 1, 2};
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.idx = i;
      b.num = exp_cnt[i];
      b.sum = exp_sum[i];
      sb.push_back(b);
    end
    while (sb.size() > 0 && cyc < 200) begin
      b = sb[0];
      if (rst_at >= 0 && b.idx == rst_at) begin
        chk("pre_rst_idx", int'(bus.out_idx), rst_at);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx", int'(bus.out_idx), 0);
        chk("rst_num", int'(bus.num_blk_CTU), 0);
        sb.delete();
        idle_inputs();
        return;
      end
      chk("out_valid", int'(bus.out_valid), 1);
      chk("out_idx", int'(bus.out_idx), b.idx);
      chk("num_blk", int'(bus.num_blk_CTU), b.num);
      chk("sum_blk", int'(bus.sum_blk_CTU), b.sum);
      if (stall && cyc < 5) chk("stall_idx", int'(bus.out_idx), stall_idx[cyc]);
      bus.out_ready = !(stall && (cyc == 1 || cyc == 2));
      start         = stall && (cyc == 2);
      bus.pix_valid = noise;
      bus.diff      = 9'sd5;
      bus.bo_band   = 5'd20;
      if (bus.out_ready) void'(sb.pop_front());
      tick();
      cyc++;
    end
    idle_inputs();
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    chk("done_pulse", int'(done), 1);
    chk("done_valid", int'(bus.out_valid), 0);
    chk("done_cycle", cyc, stall ? 50 : 48);
    tick();
    chk("done_clear", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) tbl[i] = mk(5, 1, 0, 0, 0, 7, 5);
    tbl[3]  = mk(-100, 0, 2, 0, 0, 1, -16);
    tbl[4]  = mk(100, 0, 0, 3, 0, 2, 15);
    tbl[5]  = mk(-16, 0, 0, 0, 2, 3, -16);
    tbl[6]  = mk(15, 2, 0, 0, 0, 4, 15);
    tbl[7]  = mk(16, 0, 3, 0, 0, 5, 15);
    tbl[8]  = mk(-17, 0, 0, 4, 0, 6, -16);
    tbl[9]  = mk(-3, 1, 1, 1, 1, 8, -3);
    tbl[10] = mk(0, 4, 0, 0, 0, 31, 0);
    tbl[11] = mk(7, 0, 0, 0, 4, 9, 7);
    tbl[12] = mk(15, 0, 0, 0, 0, 0, 15);

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_idx", int'(bus.out_idx), 0);
    chk("rst_num", int'(bus.num_blk_CTU), 0);
    chk("rst_sum", int'(bus.sum_blk_CTU), 0);
    rst = 1'b0;
    tick();

    // basic CTU, pixels offered during DRAIN must not disturb bins
    run_ctu(0, 2, 1, 1'b0);
    do_drain(1'b0, 1'b1, -1);

    // clipping extremes, multi-class hits, stalls and a start pulse mid-drain
    run_ctu(3, 10, 1, 1'b0);
    do_drain(1'b1, 1'b0, -1);

    // last pixel coincides with ctu_end
    run_ctu(11, 11, 1, 1'b1);
    do_drain(1'b0, 1'b0, -1);

    // count and sum saturation
    run_ctu(12, 12, 1100, 1'b0);
    do_drain(1'b0, 1'b0, -1);

    // reset mid-drain, then an empty CTU must read back all zeros
    run_ctu(0, 2, 1, 1'b0);
    do_drain(1'b0, 1'b0, 10);
    tick();
    run_ctu(1, 0, 1, 1'b0);
    do_drain(1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sao_stat_accum.md
SAO_STAT_ACCUM -- requirements
Module: sao_stat_accum

Interface
REQ-001 SHALL have parameter num_pix_CTU_log2, default 5, log2 of CTU width in pixels.
REQ-002 SHALL have parameter diff_clip_bit, default 4, clip magnitude exponent for pixel differences.
REQ-003 SHALL have parameter num_CTU, default 2*num_pix_CTU_log2-1, MSB index of count outputs.
REQ-004 SHALL have parameter sum_CTU_len, default num_CTU+diff_clip_bit, MSB index of sum outputs.
REQ-005 SHALL have parameter state_len, default 6, width of bin index.
REQ-006 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port start  input  1  one-cycle pulse; clears all bins, begins CTU accumulation.
REQ-009 SHALL have port pix_valid  input  1  qualifies pixel inputs this cycle.
REQ-010 SHALL have port diff  input  9 signed  original minus reconstructed sample.
REQ-011 SHALL have port eo_cat  input  4x3  EO category 0..4 per EO class 0..3 (0 = none).
REQ-012 SHALL have port bo_band  input  5  band index of reconstructed sample.
REQ-013 SHALL have port ctu_end  input  1  pulse; last pixel of CTU is this cycle or earlier.
REQ-014 SHALL have port out_ready  input  1  downstream consumes current bin.
REQ-015 SHALL have port out_valid  output  1  bin outputs valid.
REQ-016 SHALL have port out_idx  output  state_len  bin index (downstream cnt_dc).
REQ-017 SHALL have port num_blk_CTU  output  num_CTU+1  pixel count of bin.
REQ-018 SHALL have port sum_blk_CTU  output  sum_CTU_len+1 signed  sum of clipped diffs of bin.
REQ-019 SHALL have port busy  output  1  high in ACCUM or DRAIN.
REQ-020 SHALL have port done  output  1  one-cycle pulse after last bin accepted.

Function
REQ-021 SHALL hold 48 bins: idx 0..15 = EO class idx/4, category idx%4+1; idx 16..47 = BO band idx-16.
REQ-022 SHALL implement FSM IDLE, ACCUM, FLUSH, DRAIN; IDLE->ACCUM on start; ACCUM->FLUSH on ctu_end; FLUSH->DRAIN after one cycle; DRAIN->IDLE on acceptance of idx 47.
REQ-023 SHALL, on IDLE->ACCUM transition, clear all counts and sums in the same edge.
REQ-024 SHALL register pixel inputs in one pipeline stage, clipping diff to [-2^diff_clip_bit, 2^diff_clip_bit-1] (default -16..15).
REQ-025 SHALL, the cycle after an accepted pixel, add 1 to count and clipped diff to sum for every EO class with eo_cat!=0 (bin class*4+eo_cat-1) and for BO bin 16+bo_band, up to 5 bins in parallel.
REQ-026 SHALL accept pixels only when state is ACCUM; pix_valid in other states ignored.
REQ-027 SHALL count a pixel presented with pix_valid in the same cycle as ctu_end; FLUSH exists to retire it.
REQ-028 SHALL saturate counts at 2^(num_CTU+1)-1 and sums at signed limits of sum_CTU_len+1 bits, never wrapping.
REQ-029 SHALL in DRAIN drive out_valid=1, out_idx starting at 0, with count/sum of bin out_idx, combinationally from bin storage.
REQ-030 SHALL advance out_idx by 1 only on cycles with out_valid && out_ready; hold outputs stable otherwise.
REQ-031 SHALL pulse done one cycle, the cycle after idx 47 accepted, with out_valid=0 that cycle.
REQ-032 SHALL ignore start while busy; ignore ctu_end outside ACCUM.
REQ-033 SHALL drive out_valid=0, out_idx=0, num_blk_CTU=0, sum_blk_CTU=0 outside DRAIN.

Reset
REQ-034 SHALL on rst=1 at clock edge enter IDLE, clear all bins and pipeline stage, drive busy=0, done=0, out_valid=0, out_idx=0.
REQ-035 SHALL let rst override all other inputs, including mid-ACCUM or mid-DRAIN; no partial drain resumes.

Verification
REQ-036 SHALL cover: start, 3 pixels diff=+5, eo_cat={1,0,0,0}, band 7, ctu_end, out_ready=1 -> idx0 num=3 sum=15, idx23 num=3 sum=15, others 0, done at 48th cycle after DRAIN entry.
REQ-037 SHALL cover: pixel diff=-100 and diff=+100 -> contributed -16 and +15 respectively.
REQ-038 SHALL cover: pixel with pix_valid and ctu_end same cycle, eo_cat={0,0,0,4} -> bin 15 num=1.
REQ-039 SHALL cover: out_ready toggled 1,0,0,1 in DRAIN -> out_idx 0,1,1,1,2 with stable data during stalls.
REQ-040 SHALL cover: 1100 pixels diff=+15 band 0 -> bin 16 num=1023, sum=8191 (saturated).
REQ-041 SHALL cover: rst asserted at out_idx=10 -> next cycle IDLE, out_valid=0; new start yields cleared bins.
